// File: rtl/add_sub_seq_pkg.sv
// ----------------------------------------------------------------------------
// add_sub_seq_pkg
//   Shared definitions for the nibble-serial add/subtract sequencer:
//   nibble width, default operand width in nibbles, and the FSM state encoding.
// ----------------------------------------------------------------------------
package add_sub_seq_pkg;

   localparam int NIB_W       = 4;
   localparam int NIBBLES_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      CHECK = 3'd2,
      VOTE  = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/add_sub_nibble_seq_vote3.sv
// ----------------------------------------------------------------------------
// nibble_vote3
//   Bitwise 2-of-3 majority over three {carry, sum} nibble results, plus a
//   flag raised when the three values are not all identical.
// Ports:
//   v0, v1, v2  in   NIB_W+1  candidate {cout, sum} results
//   maj         out  NIB_W+1  bitwise majority
//   mismatch    out  1        any candidate differs from another
// ----------------------------------------------------------------------------
module nibble_vote3
   import add_sub_seq_pkg::*;
(
   input  logic [NIB_W:0] v0,
   input  logic [NIB_W:0] v1,
   input  logic [NIB_W:0] v2,
   output logic [NIB_W:0] maj,
   output logic           mismatch
);

   assign maj      = (v0 & v1) | (v0 & v2) | (v1 & v2);
   assign mismatch = (v0 != v1) | (v1 != v2);

endmodule

// File: rtl/add_sub_nibble_seq.sv
// ----------------------------------------------------------------------------
// add_sub_nibble_seq
//   Performs a W = 4*NIBBLES bit add or subtract by sequencing one external
//   4-bit combinational adder, least significant nibble first. The carry is
//   registered between nibbles; B inversion and carry-in for subtraction are
//   generated here. The result, final carry and signed overflow are returned
//   over a valid/ready handshake and held until the next result.
//
//   Optional macro ADD_SUB_SEQ_RECHECK_EN: every nibble is evaluated twice
//   (CALC, CHECK); on disagreement a third evaluation (VOTE) is majority-voted
//   and out_fault is set for the transaction. Without it out_fault is 0.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid / out_ready     operand handshake
//   in_a, in_b, in_mode      operands; mode 0 = A+B, 1 = A-B
//   out_valid / in_ready     result handshake
//   out_sum, out_cout        result and carry (subtract: 1 = no borrow)
//   out_ovf, out_fault       signed overflow, redundancy mismatch seen
//   add_a, add_b, add_cin    operands presented to the external adder
//   add_sum, add_cout        external adder result
// ----------------------------------------------------------------------------
module add_sub_nibble_seq
   import add_sub_seq_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     out_ready,
   input  logic [NIB_W*NIBBLES-1:0] in_a,
   input  logic [NIB_W*NIBBLES-1:0] in_b,
   input  logic                     in_mode,
   output logic                     out_valid,
   input  logic                     in_ready,
   output logic [NIB_W*NIBBLES-1:0] out_sum,
   output logic                     out_cout,
   output logic                     out_ovf,
   output logic                     out_fault,
   output logic [NIB_W-1:0]         add_a,
   output logic [NIB_W-1:0]         add_b,
   output logic                     add_cin,
   input  logic [NIB_W-1:0]         add_sum,
   input  logic                     add_cout
);

   localparam int              W      = NIB_W * NIBBLES;
   localparam int              KW     = $clog2(NIBBLES);
   localparam logic [KW-1:0]   K_LAST = KW'(NIBBLES - 1);

   state_t          state, state_nx;
   logic [W-1:0]    a_q, b_q, res_q, res_nx;
   logic            mode_q, carry_q;
   logic [KW-1:0]   k_q;
   logic [NIB_W:0]  live;      // {cout, sum} from the adder this cycle
   logic [NIB_W:0]  nib;       // value committed for nibble k
   logic            commit, last, accept, nib_ovf;

   assign live      = {add_cout, add_sum};
   assign out_ready = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & out_ready;
   assign last      = (k_q == K_LAST);

   // Adder operands are only driven while a nibble is being evaluated.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == CALC || state == CHECK || state == VOTE) begin
         add_a   = a_q[k_q*NIB_W +: NIB_W];
         add_b   = b_q[k_q*NIB_W +: NIB_W] ^ {NIB_W{mode_q}};
         add_cin = carry_q;
      end
   end

`ifdef ADD_SUB_SEQ_RECHECK_EN
   logic [NIB_W:0] eval1_q, eval2_q, vote_v1;
   logic           mismatch, fault_q, out_fault_q;

   // In CHECK the voter sees (first, live, live): majority is the live value
   // and mismatch is simply first != live. In VOTE it sees all three.
   assign vote_v1 = (state == VOTE) ? eval2_q : live;

   nibble_vote3 u_vote (
      .v0       (eval1_q),
      .v1       (vote_v1),
      .v2       (live),
      .maj      (nib),
      .mismatch (mismatch)
   );

   assign commit    = (state == CHECK && !mismatch) || (state == VOTE);
   assign out_fault = out_fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval1_q     <= '0;
         eval2_q     <= '0;
         fault_q     <= 1'b0;
         out_fault_q <= 1'b0;
      end else begin
         if (state == CALC)  eval1_q <= live;
         if (state == CHECK) eval2_q <= live;
         if (accept)
            fault_q <= 1'b0;
         else if (state == VOTE)
            fault_q <= 1'b1;
         if (commit && last)
            out_fault_q <= fault_q | (state == VOTE);
      end
   end
`else
   assign nib       = live;
   assign commit    = (state == CALC);
   assign out_fault = 1'b0;
`endif

   // Carry into the MSB of the nibble is recovered from sum ^ a ^ b.
   assign nib_ovf = nib[NIB_W-1] ^ add_a[NIB_W-1] ^ add_b[NIB_W-1] ^ nib[NIB_W];

   always_comb begin
      res_nx = res_q;
      res_nx[k_q*NIB_W +: NIB_W] = nib[NIB_W-1:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = CALC;
         CALC, CHECK, VOTE: begin
            if (commit)
               state_nx = last ? DONE : CALC;
`ifdef ADD_SUB_SEQ_RECHECK_EN
            else if (state == CALC)
               state_nx = CHECK;
            else if (state == CHECK)
               state_nx = VOTE;
`endif
         end
         DONE: if (in_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         carry_q  <= 1'b0;
         k_q      <= '0;
         res_q    <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else if (accept) begin
         a_q     <= in_a;
         b_q     <= in_b;
         mode_q  <= in_mode;
         carry_q <= in_mode;
         k_q     <= '0;
         res_q   <= '0;
      end else if (commit) begin
         res_q   <= res_nx;
         carry_q <= nib[NIB_W];
         if (last) begin
            out_sum  <= res_nx;
            out_cout <= nib[NIB_W];
            out_ovf  <= nib_ovf;
         end else begin
            k_q <= k_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_add_sub_nibble_seq.sv
module tb_add_sub_nibble_seq;

   localparam int NIBBLES = 4;
   localparam int W       = 16;
`ifdef ADD_SUB_SEQ_RECHECK_EN
   localparam int LAT  = 9;
   localparam int STEP = 2;
`else
   localparam int LAT  = 5;
   localparam int STEP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, out_ready, in_mode, out_valid, in_ready;
   logic [W-1:0]  in_a, in_b, out_sum;
   logic          out_cout, out_ovf, out_fault;
   logic [3:0]    add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic          inj;
   logic [4:0]    add_raw;

   int            total = 0;
   int            bad   = 0;
   logic [3:0]    mon_b   [8];
   logic          mon_cin [8];

   always #5 clk = ~clk;

   add_sub_nibble_seq #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_fault (out_fault),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout)
   );

   // Ideal 4-bit adder; inj flips sum bit 1 to emulate a transient upset.
   always_comb begin
      add_raw  = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
      add_sum  = add_raw[3:0] ^ {2'b00, inj, 1'b0};
      add_cout = add_raw[4];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic mode, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf, input logic efault, input int elat, input int inj_at);
      int lat;
      @(negedge clk);
      in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1; in_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      inj = (lat == inj_at);
      mon_b[0] = add_b; mon_cin[0] = add_cin;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         inj = (lat == inj_at);
         if (lat <= 8) begin
            mon_b[lat-1]   = add_b;
            mon_cin[lat-1] = add_cin;
         end
      end
      inj = 1'b0;
      chk({tag, ".lat"},   lat,       elat);
      chk({tag, ".sum"},   out_sum,   esum);
      chk({tag, ".cout"},  out_cout,  ecout);
      chk({tag, ".ovf"},   out_ovf,   eovf);
      chk({tag, ".fault"}, out_fault, efault);
      chk({tag, ".rdy"},   out_ready, 1'b0);
      @(posedge clk); #1;
      chk({tag, ".vld_off"}, out_valid, 1'b0);
      chk({tag, ".hold"},    out_sum,   esum);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_mode = 1'b0;
      in_a = '0; in_b = '0; inj = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.rdy",   out_ready, 1'b1);
      chk("rst.vld",   out_valid, 1'b0);
      chk("rst.sum",   out_sum,   16'h0);
      chk("rst.cout",  out_cout,  1'b0);
      chk("rst.ovf",   out_ovf,   1'b0);
      chk("rst.fault", out_fault, 1'b0);
      chk("rst.adda",  add_a,     4'h0);
      chk("rst.addb",  add_b,     4'h0);
      chk("rst.cin",   add_cin,   1'b0);
      @(negedge clk); rst_n = 1'b1;

      run_txn("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, LAT, -1);

      run_txn("sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, LAT, -1);
      chk("sub.cin0", mon_cin[0],      1'b1);
      chk("sub.b0",   mon_b[0],        4'h8);
      chk("sub.b1",   mon_b[STEP],     4'hF);
      chk("sub.b2",   mon_b[2*STEP],   4'hF);
      chk("sub.b3",   mon_b[3*STEP],   4'hF);

      run_txn("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, LAT, -1);
      run_txn("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, LAT, -1);
      run_txn("zero",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, LAT, -1);
      run_txn("ovfsub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, LAT, -1);

      // Reset in the middle of a transaction
      @(negedge clk);
      in_a = 16'h1234; in_b = 16'h0FFF; in_mode = 1'b0; in_valid = 1'b1; in_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid.busy", out_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid.vld",   out_valid, 1'b0);
      chk("mid.sum",   out_sum,   16'h0);
      chk("mid.cout",  out_cout,  1'b0);
      chk("mid.ovf",   out_ovf,   1'b0);
      chk("mid.adda",  add_a,     4'h0);
      chk("mid.addb",  add_b,     4'h0);
      chk("mid.cin",   add_cin,   1'b0);
      chk("mid.rdy",   out_ready, 1'b1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid.rdy2", out_ready, 1'b1);
      chk("mid.vld2", out_valid, 1'b0);
      run_txn("post", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, LAT, -1);

      // Backpressure in DONE with in_valid toggling
      @(negedge clk);
      in_a = 16'h00FF; in_b = 16'h0001; in_mode = 1'b0; in_valid = 1'b1; in_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("bp.vld", out_valid, 1'b1);
      chk("bp.sum", out_sum,   16'h0100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_a = 16'hAAAA + 16'(i); in_b = 16'h5555; in_mode = 1'(i);
         @(posedge clk); #1;
         chk("bp.hold_vld", out_valid, 1'b1);
         chk("bp.hold_rdy", out_ready, 1'b0);
         chk("bp.hold_sum", out_sum,   16'h0100);
      end
      @(negedge clk); in_valid = 1'b0; in_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp.done_vld", out_valid, 1'b0);
      chk("bp.done_rdy", out_ready, 1'b1);
      chk("bp.done_sum", out_sum,   16'h0100);
      @(posedge clk); #1;
      chk("bp.idle", out_ready, 1'b1);

`ifdef ADD_SUB_SEQ_RECHECK_EN
      run_txn("inj",   16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1, 10, 3);
      run_txn("clean", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 9, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
